// File: rtl/ifu_if.sv
// Fetch-unit handshake bundle: instruction-memory request/response,
// decoder hand-off, and execute next-PC feedback.
interface ifu_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic        imem_resp_ready;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        halt;
   logic        npc_valid;
   logic [31:0] npc;
   logic        halted;
   logic [31:0] fetch_count;

   modport master (
      output imem_req_valid, imem_req_addr, imem_resp_ready,
             inst_valid, inst, pc, halted, fetch_count,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
             inst_ready, halt, npc_valid, npc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, imem_resp_ready,
             inst_valid, inst, pc, halted, fetch_count,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
             inst_ready, halt, npc_valid, npc
   );
endinterface

// File: rtl/ifu.sv
// Non-pipelined instruction fetch unit: one instruction in flight, next PC
// supplied by execute, stops permanently on a halting instruction until reset.
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic  clk,
   input  logic  rst,
   ifu_if.master bus
);

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT_RESP,
      S_HOLD,
      S_WAIT_NPC,
      S_HALTED
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] cnt_q;

   logic req_fire, resp_fire, inst_fire, npc_fire;

   // Every handshake is qualified by the current state so that strobes
   // arriving in the wrong phase are ignored.
   assign req_fire  = (state_q == S_REQ)       && bus.imem_req_ready;
   assign resp_fire = (state_q == S_WAIT_RESP) && bus.imem_resp_valid;
   assign inst_fire = (state_q == S_HOLD)      && bus.inst_ready;
   assign npc_fire  = (state_q == S_WAIT_NPC)  && bus.npc_valid;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_REQ:       if (req_fire)  state_d = S_WAIT_RESP;
         S_WAIT_RESP: if (resp_fire) state_d = S_HOLD;
         S_HOLD:      if (inst_fire) state_d = bus.halt ? S_HALTED : S_WAIT_NPC;
         S_WAIT_NPC:  if (npc_fire)  state_d = S_REQ;
         S_HALTED:    state_d = S_HALTED;
         default:     state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         inst_q  <= NOP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (resp_fire) inst_q <= bus.imem_resp_data;
         if (npc_fire)  pc_q   <= {bus.npc[31:2], 2'b00};
         if (inst_fire) cnt_q  <= cnt_q + 32'd1;
      end
   end

   // Outputs come only from state and registers; no input reaches an output.
   assign bus.imem_req_valid  = (state_q == S_REQ);
   assign bus.imem_req_addr   = pc_q;
   assign bus.imem_resp_ready = (state_q == S_WAIT_RESP);
   assign bus.inst_valid      = (state_q == S_HOLD);
   assign bus.inst            = inst_q;
   assign bus.pc              = pc_q;
   assign bus.halted          = (state_q == S_HALTED);
   assign bus.fetch_count     = cnt_q;

   // PC is forced word aligned, so the low npc bits carry no information.
   logic unused_npc_lsb;
   assign unused_npc_lsb = ^bus.npc[1:0];

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset, fetch timing, stalls, spurious strobes,
// halt behaviour, next-PC alignment and reset during an outstanding fetch.
module tb_ifu;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   ifu_if bus ();

   ifu #(.RESET_PC(32'h8000_0000)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.inst_ready      = 1'b0;
      bus.halt            = 1'b0;
      bus.npc_valid       = 1'b0;
      bus.npc             = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic fetch_to_hold(input logic [31:0] data);
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = data;
      step();
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
   endtask

   task automatic retire(input logic [31:0] next_pc);
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
      bus.npc_valid  = 1'b1;
      bus.npc        = next_pc;
      step();
      bus.npc_valid  = 1'b0;
      bus.npc        = 32'h0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000) begin
         bad++;
         $display("FAIL reset_req: valid=%b addr=%h want 1 80000000", bus.imem_req_valid, bus.imem_req_addr);
      end
      total++;
      if (bus.inst !== 32'h0000_0013 || bus.pc !== 32'h8000_0000) begin
         bad++;
         $display("FAIL reset_inst_pc: inst=%h pc=%h want 00000013 80000000", bus.inst, bus.pc);
      end
      total++;
      if (bus.fetch_count !== 32'd0 || bus.halted !== 1'b0 || bus.inst_valid !== 1'b0 ||
          bus.imem_resp_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_misc: cnt=%0d halted=%b iv=%b rr=%b want 0 0 0 0",
                  bus.fetch_count, bus.halted, bus.inst_valid, bus.imem_resp_ready);
      end
   endtask

   task automatic test_basic_fetch();
      do_reset();
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      total++;
      if (bus.imem_resp_ready !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_wait_resp: rr=%b rv=%b iv=%b want 1 0 0",
                  bus.imem_resp_ready, bus.imem_req_valid, bus.inst_valid);
      end
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'h0010_0093;
      step();
      bus.imem_resp_valid = 1'b0;
      total++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0010_0093 || bus.pc !== 32'h8000_0000) begin
         bad++;
         $display("FAIL basic_hold: iv=%b inst=%h pc=%h want 1 00100093 80000000",
                  bus.inst_valid, bus.inst, bus.pc);
      end
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
      total++;
      if (bus.inst_valid !== 1'b0 || bus.fetch_count !== 32'd1 || bus.imem_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_retire: iv=%b cnt=%0d rv=%b want 0 1 0",
                  bus.inst_valid, bus.fetch_count, bus.imem_req_valid);
      end
      bus.npc_valid = 1'b1;
      bus.npc       = 32'h8000_0004;
      step();
      bus.npc_valid = 1'b0;
      total++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0004 || bus.pc !== 32'h8000_0004) begin
         bad++;
         $display("FAIL basic_next_req: rv=%b addr=%h pc=%h want 1 80000004 80000004",
                  bus.imem_req_valid, bus.imem_req_addr, bus.pc);
      end
   endtask

   task automatic test_req_stall();
      do_reset();
      bus.npc_valid = 1'b1;
      bus.npc       = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000 ||
             bus.imem_resp_ready !== 1'b0) begin
            bad++;
            $display("FAIL req_stall[%0d]: rv=%b addr=%h rr=%b want 1 80000000 0",
                     i, bus.imem_req_valid, bus.imem_req_addr, bus.imem_resp_ready);
         end
      end
      bus.npc_valid = 1'b0;
   endtask

   task automatic test_hold_stall();
      do_reset();
      fetch_to_hold(32'h00a0_0113);
      bus.inst_ready      = 1'b0;
      bus.npc_valid       = 1'b1;
      bus.npc             = 32'hDEAD_BEEF;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'h0;
      bus.halt            = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h00a0_0113 || bus.pc !== 32'h8000_0000 ||
             bus.fetch_count !== 32'd0 || bus.halted !== 1'b0) begin
            bad++;
            $display("FAIL hold_stall[%0d]: iv=%b inst=%h pc=%h cnt=%0d halted=%b want 1 00a00113 80000000 0 0",
                     i, bus.inst_valid, bus.inst, bus.pc, bus.fetch_count, bus.halted);
         end
      end
      idle_inputs();
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
      total++;
      if (bus.fetch_count !== 32'd1 || bus.inst_valid !== 1'b0 || bus.halted !== 1'b0) begin
         bad++;
         $display("FAIL hold_release: cnt=%0d iv=%b halted=%b want 1 0 0",
                  bus.fetch_count, bus.inst_valid, bus.halted);
      end
   endtask

   task automatic test_halt();
      do_reset();
      fetch_to_hold(32'h0010_0073);
      bus.inst_ready = 1'b1;
      bus.halt       = 1'b1;
      step();
      idle_inputs();
      total++;
      if (bus.halted !== 1'b1 || bus.inst_valid !== 1'b0 || bus.fetch_count !== 32'd1) begin
         bad++;
         $display("FAIL halt_enter: halted=%b iv=%b cnt=%0d want 1 0 1",
                  bus.halted, bus.inst_valid, bus.fetch_count);
      end
      bus.npc_valid       = 1'b1;
      bus.npc             = 32'h8000_0040;
      bus.imem_req_ready  = 1'b1;
      bus.imem_resp_valid = 1'b1;
      bus.inst_ready      = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         total++;
         if (bus.imem_req_valid !== 1'b0 || bus.halted !== 1'b1 || bus.inst_valid !== 1'b0 ||
             bus.imem_resp_ready !== 1'b0 || bus.pc !== 32'h8000_0000) begin
            bad++;
            $display("FAIL halt_stay[%0d]: rv=%b halted=%b iv=%b rr=%b pc=%h want 0 1 0 0 80000000",
                     i, bus.imem_req_valid, bus.halted, bus.inst_valid, bus.imem_resp_ready, bus.pc);
         end
      end
      do_reset();
      total++;
      if (bus.halted !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000) begin
         bad++;
         $display("FAIL halt_reset: halted=%b rv=%b addr=%h want 0 1 80000000",
                  bus.halted, bus.imem_req_valid, bus.imem_req_addr);
      end
   endtask

   task automatic test_npc_align();
      do_reset();
      fetch_to_hold(32'h0000_0013);
      retire(32'h8000_0103);
      total++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0100) begin
         bad++;
         $display("FAIL npc_align: rv=%b addr=%h want 1 80000100", bus.imem_req_valid, bus.imem_req_addr);
      end
      // Back-to-back second fetch lands on the aligned address.
      fetch_to_hold(32'h0020_0193);
      total++;
      if (bus.inst !== 32'h0020_0193 || bus.pc !== 32'h8000_0100 || bus.fetch_count !== 32'd1) begin
         bad++;
         $display("FAIL npc_second: inst=%h pc=%h cnt=%0d want 00200193 80000100 1",
                  bus.inst, bus.pc, bus.fetch_count);
      end
   endtask

   task automatic test_rst_wait_resp();
      do_reset();
      fetch_to_hold(32'h0000_0013);
      retire(32'h8000_0008);
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      // Now in WAIT_RESP with fetch_count=1; reset while the response arrives.
      rst                 = 1'b1;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hFFFF_FFFF;
      step();
      rst = 1'b0;
      total++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000 ||
          bus.fetch_count !== 32'd0 || bus.inst !== 32'h0000_0013) begin
         bad++;
         $display("FAIL rst_resp: rv=%b addr=%h cnt=%0d inst=%h want 1 80000000 0 00000013",
                  bus.imem_req_valid, bus.imem_req_addr, bus.fetch_count, bus.inst);
      end
      step();
      bus.imem_resp_valid = 1'b0;
      total++;
      if (bus.inst !== 32'h0000_0013 || bus.imem_resp_ready !== 1'b0 || bus.imem_req_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_resp_ignored: inst=%h rr=%b rv=%b want 00000013 0 1",
                  bus.inst, bus.imem_resp_ready, bus.imem_req_valid);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle_inputs();
      test_reset();
      test_basic_fetch();
      test_req_stall();
      test_hold_stall();
      test_halt();
      test_npc_align();
      test_rst_wait_resp();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameter RESET_PC, default 32'h8000_0000: PC loaded on reset.
REQ-003 Ports SHALL be:
- clk  input  1  sole clock; all state changes on posedge
- rst  input  1  synchronous active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address (word aligned)
- imem_resp_valid  input  1  fetch data valid
- imem_resp_ready  output  1  IFU accepts response
- imem_resp_data  input  32  fetched instruction word
- inst_valid  output  1  instruction presented to decoder
- inst_ready  input  1  decode/execute accepts instruction
- inst  output  32  instruction word to decoder
- pc  output  32  address of inst
- halt  input  1  decoder halt (ebreak) for presented inst
- npc_valid  input  1  next-PC strobe from execute
- npc  input  32  next-PC value
- halted  output  1  fetch stopped after ebreak
- fetch_count  output  32  retired-fetch counter

Function
REQ-004 FSM states SHALL be REQ, WAIT_RESP, HOLD, WAIT_NPC, HALTED; one state per cycle, no bypass paths.
REQ-005 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_valid&imem_req_ready go WAIT_RESP, else stay with addr stable.
REQ-006 WAIT_RESP: imem_resp_ready=1; on imem_resp_valid latch imem_resp_data into inst, go HOLD; else stay.
REQ-007 imem_resp_ready SHALL be 0 outside WAIT_RESP; imem_resp_valid outside WAIT_RESP SHALL be ignored (inst unchanged).
REQ-008 HOLD: inst_valid=1; inst and pc stable until inst_valid&inst_ready.
REQ-009 On handshake in HOLD: fetch_count increments by 1 (wraps 32'hFFFF_FFFF -> 0); next state HALTED if halt=1 that cycle, else WAIT_NPC.
REQ-010 WAIT_NPC: on npc_valid load pc <= {npc[31:2],2'b00}, go REQ; else stay.
REQ-011 npc_valid in any state other than WAIT_NPC SHALL be ignored (pc unchanged).
REQ-012 HALTED: terminal until rst; halted=1; imem_req_valid=0, inst_valid=0, imem_resp_ready=0.
REQ-013 halt sampled only at the HOLD handshake; halt=1 without handshake SHALL have no effect.
REQ-014 pc SHALL change only on reset or REQ-010; inst only on REQ-006.
REQ-015 Minimum instruction-to-instruction time with zero-wait memory and immediate npc_valid/inst_ready: 4 cycles (REQ, WAIT_RESP, HOLD, WAIT_NPC).
REQ-016 All outputs SHALL be registered or decoded from state register only; no combinational path input->output.

Reset
REQ-017 rst=1 at posedge: state<=REQ, pc<=RESET_PC, inst<=32'h0000_0013 (nop), fetch_count<=0, halted<=0.
REQ-018 Reset SHALL take priority over every state, including mid-request, mid-response and HALTED; in-flight handshake discarded.
REQ-019 First cycle after rst deasserts: imem_req_valid=1, imem_req_addr=RESET_PC.

Verification
REQ-020 Scenarios:
- Reset release, zero-wait mem returning 32'h00100093, inst_ready=1, npc=32'h8000_0004 one cycle after handshake -> inst_valid high 2 cycles after reset release, pc=32'h8000_0000; next request addr 32'h8000_0004; fetch_count=1.
- imem_req_ready low 3 cycles -> imem_req_addr stable 32'h8000_0000, state stays REQ, no imem_resp_ready.
- Inst presented, inst_ready low 5 cycles, spurious npc_valid npc=32'hDEAD_BEEF and imem_resp_valid data 32'h0 asserted -> inst, pc unchanged, fetch_count unchanged.
- Inst 32'h0010_0073 with halt=1 at handshake -> halted=1 next cycle, no further imem_req_valid for 20 cycles despite npc_valid; rst -> request 32'h8000_0000 again.
- npc=32'h8000_0103 -> imem_req_addr 32'h8000_0100.
- rst pulsed in WAIT_RESP, then response arrives -> response ignored, new request at RESET_PC, fetch_count=0.
